ttt_board_overlay_core: RTL and testbench
=========================================

Name: ttt_board_overlay_core

Overview:
Video daisy-chain core that overlays a 3x3 tic-tac-toe board on the incoming pixel stream. It draws the grid, X/O marks per cell, a blinking cursor outline and win-cell fills. It occupies slot V1 and directly feeds the merged line-data input of the VGA sync core. The board state is set by software over the slot register bus and committed at frame start, so each frame is drawn without tearing.

Parameters:
CD, 12, colour depth of si_rgb/so_rgb and colour registers
CELL_LOG2, 6, log2 of cell size in pixels; default gives 64 px cells and a 192x192 board
LW, 4, grid and cursor line width in pixels
XY_DLY, 2, cycles x/y are delayed internally to align with si_rgb

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
x  in  11  pixel column from frame counter
y  in  11  pixel row from frame counter
cs  in  1  slot chip select
write  in  1  slot write strobe
addr  in  14  slot register address; only addr[2:0] decoded
wr_data  in  32  slot write data
si_rgb  in  CD  upstream pixel, aligned with x/y delayed by XY_DLY
so_rgb  out  CD  overlaid pixel, registered

Behaviour:
- Reset is asynchronous and active-low. It clears all registers, shadows, delay lines, the frame counter and so_rgb to 0 (board disabled).
- Register writes occur on cs&&write; reads are not supported.
  - 0 CTRL: bit0 enable, bit1 blink_en.
  - 1 ORIGIN: board top-left; x0 = wr_data[9:0], y0 = wr_data[25:16].
  - 2 CELLS (pending): cell i = wr_data[2i+1:2i], i = 0..8, row-major. Codes: 00 empty, 01 X, 10 O, 11 win.
  - 3 CURSOR (pending): wr_data[3:0]; values 9-15 mean no cursor.
  - 4 COLOR_A: X colour [11:0], O colour [23:12].
  - 5 COLOR_B: grid colour [11:0], cursor/win colour [23:12].
  - Addresses 6-7 are ignored.
- CTRL, ORIGIN and colour registers take effect on the cycle after the write.
- Double buffering:
  - frame_tick is asserted when delayed x==0 && y==0.
  - On frame_tick, the active CELLS/CURSOR copies load from pending.
  - If a pending write happens in the same cycle as frame_tick, the written value bypasses into the active copy.
- Frame counter: a 5-bit counter increments on each frame_tick and wraps 31 to 0. Cursor is visible when blink_en==0 or counter[4]==0, giving a 32-frame blink period.
- Geometry, all on delayed coordinates xd/yd:
  - rx = xd - x0 and ry = yd - y0, computed 11-bit signed.
  - Pixel is inside the board iff 0 <= rx < 3*2^CELL_LOG2 and likewise for ry.
  - Column = rx >> CELL_LOG2, row likewise; dx, dy = low CELL_LOG2 bits.
  - No multipliers; cell index = 3*row + col via shift-add.
- Pixel classes, with C = 2^CELL_LOG2 and M = C/8:
  - grid: dx < LW or dy < LW, or rx >= 3C-LW, or ry >= 3C-LW.
  - X: dx and dy both in [M, C-M), and |dx-dy| < LW or |dx+dy-(C-1)| < LW.
  - O: with h = C/2 - 1 and R = C/2 - M, R-LW < |dx-h|+|dy-h| <= R (diamond outline).
  - cursor: pixel is in the cursor cell and in [0, LW) or (C-LW-1, C-1] on either axis.
  - win: code 11; whole cell interior (not grid) filled.
- Priority: cursor > X/O > win fill > grid > si_rgb.
- Output:
  - When enable==0 or outside the board, so_rgb = si_rgb delayed 1 cycle.
  - Latency is exactly 1 cycle from si_rgb to so_rgb.
  - Class logic and the si_rgb pipeline register stay in lockstep.
- Coordinate delay line: XY_DLY register stages. XY_DLY=0 is legal and means no delay.
- Board extending past x=639 or y=479 is clipped naturally with no wrap, because rx is compared against the limit unsigned after the sign check.

Test Plan:
- Reset: hold reset=0 mid-frame with si_rgb=12'h008 → so_rgb=0. After release with enable=0, so_rgb equals si_rgb one cycle later, e.g. 12'h008.
- Grid: ORIGIN x0=100, y0=50; COLOR_B grid=12'hFFF; enable=1 → pixel (100,50) is 12'hFFF, (164,60) is 12'hFFF, (120,70) passes si_rgb, (292,50) passes si_rgb.
- Marks: CELLS=18'h00009 (cell0=X, cell1=O), COLOR_A=12'h0F0/12'hF00; write mid-frame → no change until next frame_tick. Then (100+20,50+20) is 12'h0F0 and cell1 diamond vertex (164+31,50+8) is 12'hF00.
- Bypass: write CELLS in the exact frame_tick cycle → new value drawn in that frame.
- Blink: CURSOR=4, blink_en=1, cursor colour 12'hFF0 → outline of cell4 is 12'hFF0 for frames 0-15, absent for frames 16-31, and repeats after the counter wraps. CURSOR=12 → no outline ever.
- Win/priority: cell4=11 with cursor=4 → interior filled 12'hFF0 and outline 12'hFF0. Cell4=01 with cursor on it → cursor overrides X on the overlapping border pixels.

Source files
------------

// File: rtl/ttt_board_overlay_core.sv
// Tic-tac-toe board overlay for the video daisy chain: grid, X/O marks, blinking
// cursor outline and win fills drawn over si_rgb with one cycle of latency.
module ttt_board_overlay_core #(
  parameter int CD        = 12,
  parameter int CELL_LOG2 = 6,
  parameter int LW        = 4,
  parameter int XY_DLY    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int C     = 1 << CELL_LOG2;
  localparam int M     = C / 8;
  localparam int H     = C / 2 - 1;
  localparam int R     = C / 2 - M;
  localparam int BOARD = 3 * C;
  localparam int W     = CELL_LOG2 + 1;

  logic [10:0] xd, yd;

  generate
    if (XY_DLY == 0) begin : g_nodly
      assign xd = x;
      assign yd = y;
    end else begin : g_dly
      localparam int SW = XY_DLY * 11;
      logic [SW-1:0] xs, ys;
      // Flat shift register: new sample enters at the bottom, oldest leaves the top.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          xs <= '0;
          ys <= '0;
        end else begin
          xs <= SW'({xs, x});
          ys <= SW'({ys, y});
        end
      end
      assign xd = xs[SW-1 -: 11];
      assign yd = ys[SW-1 -: 11];
    end
  endgenerate

  logic          enable, blink_en;
  logic [9:0]    x0, y0;
  logic [17:0]   cells_pend, cells_act;
  logic [3:0]    cur_pend, cur_act;
  logic [CD-1:0] col_x, col_o, col_grid, col_cur;
  logic [4:0]    frame_cnt;

  logic wr_en, frame_tick;
  assign wr_en      = cs && write;
  assign frame_tick = (xd == 11'd0) && (yd == 11'd0);

  logic unused_ok;
  assign unused_ok = ^{addr[13:3], wr_data[31:26]};

  // Geometry relative to the board origin
  logic [10:0]  rx, ry;
  logic         in_board;
  logic [1:0]   col, row;
  logic [3:0]   idx;
  logic [W-1:0] dx, dy;
  logic [1:0]   code;

  assign rx       = xd - {1'b0, x0};
  assign ry       = yd - {1'b0, y0};
  assign in_board = !rx[10] && (rx < 11'(BOARD)) && !ry[10] && (ry < 11'(BOARD));
  assign col      = rx[CELL_LOG2 +: 2];
  assign row      = ry[CELL_LOG2 +: 2];
  assign idx      = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  assign dx       = {1'b0, rx[CELL_LOG2-1:0]};
  assign dy       = {1'b0, ry[CELL_LOG2-1:0]};
  assign code     = 2'(cells_act >> {idx, 1'b0});

  logic         is_grid, in_mark, is_x, is_o, cur_vis, cur_edge;
  logic [W-1:0] adiff, dsum, adiag, ahx, ahy, osum;

  always_comb begin
    is_grid = (dx < W'(LW)) || (dy < W'(LW)) ||
              (rx >= 11'(BOARD - LW)) || (ry >= 11'(BOARD - LW));
    in_mark = (dx >= W'(M)) && (dx < W'(C - M)) && (dy >= W'(M)) && (dy < W'(C - M));
    adiff   = (dx >= dy) ? dx - dy : dy - dx;
    dsum    = dx + dy;
    adiag   = (dsum >= W'(C - 1)) ? dsum - W'(C - 1) : W'(C - 1) - dsum;
    is_x    = in_mark && ((adiff < W'(LW)) || (adiag < W'(LW)));
    ahx     = (dx >= W'(H)) ? dx - W'(H) : W'(H) - dx;
    ahy     = (dy >= W'(H)) ? dy - W'(H) : W'(H) - dy;
    osum    = ahx + ahy;
    is_o    = (osum > W'(R - LW)) && (osum <= W'(R));
    cur_vis = (cur_act < 4'd9) && (!blink_en || !frame_cnt[4]) && (cur_act == idx);
    cur_edge = (dx < W'(LW)) || (dx > W'(C - LW - 1)) ||
               (dy < W'(LW)) || (dy > W'(C - LW - 1));
  end

  logic [CD-1:0] pix;

  always_comb begin
    pix = si_rgb;
    if (enable && in_board) begin
      if (cur_vis && cur_edge)          pix = col_cur;
      else if (code == 2'b01 && is_x)   pix = col_x;
      else if (code == 2'b10 && is_o)   pix = col_o;
      else if (code == 2'b11 && !is_grid) pix = col_cur;
      else if (is_grid)                 pix = col_grid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable     <= 1'b0;
      blink_en   <= 1'b0;
      x0         <= '0;
      y0         <= '0;
      cells_pend <= '0;
      cells_act  <= '0;
      cur_pend   <= '0;
      cur_act    <= '0;
      col_x      <= '0;
      col_o      <= '0;
      col_grid   <= '0;
      col_cur    <= '0;
      frame_cnt  <= '0;
      so_rgb     <= '0;
    end else begin
      if (wr_en) begin
        case (addr[2:0])
          3'd0: begin enable <= wr_data[0]; blink_en <= wr_data[1]; end
          3'd1: begin x0 <= wr_data[9:0]; y0 <= wr_data[25:16]; end
          3'd2: cells_pend <= wr_data[17:0];
          3'd3: cur_pend <= wr_data[3:0];
          3'd4: begin col_x <= wr_data[CD-1:0]; col_o <= wr_data[12 +: CD]; end
          3'd5: begin col_grid <= wr_data[CD-1:0]; col_cur <= wr_data[12 +: CD]; end
          default: ;
        endcase
      end
      // A pending write landing on the tick cycle goes straight to the active copy.
      if (frame_tick) begin
        frame_cnt <= frame_cnt + 5'd1;
        cells_act <= (wr_en && addr[2:0] == 3'd2) ? wr_data[17:0] : cells_pend;
        cur_act   <= (wr_en && addr[2:0] == 3'd3) ? wr_data[3:0] : cur_pend;
      end
      so_rgb <= pix;
    end
  end

endmodule

// File: tb/tb_ttt_board_overlay_core.sv
// Directed self-checking bench for ttt_board_overlay_core (64 px cells, LW=4, XY_DLY=2).
module tb_ttt_board_overlay_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [11:0] si_rgb, so_rgb;

  int errors = 0;
  int checks = 0;
  int fcnt   = 0;
  logic [11:0] got, exp;

  always #5 clk = ~clk;

  ttt_board_overlay_core #(.CD(12), .CELL_LOG2(6), .LW(4), .XY_DLY(2)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
    .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = {11'd0, a}; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  // Holds one coordinate until it has crossed the delay line and the output register.
  task automatic px(input int xx, input int yy, input logic [11:0] si, output logic [11:0] o);
    @(negedge clk);
    x = 11'(xx); y = 11'(yy); si_rgb = si;
    repeat (3) @(posedge clk);
    #1 o = so_rgb;
  endtask

  // Presents (0,0) for exactly one pixel so exactly one frame_tick follows.
  task automatic frame();
    @(negedge clk);
    x = 11'd0; y = 11'd0;
    @(negedge clk);
    x = 11'd1;
    fcnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    x = 11'd5; y = 11'd5; si_rgb = 12'h008;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (so_rgb !== 12'h000) begin errors++; $display("FAIL reset_out: got %h expected %h", so_rgb, 12'h000); end
    @(negedge clk);
    reset = 1'b1;
    // Delay line comes out of reset holding (0,0): two frame ticks follow release.
    fcnt = 2;
    @(posedge clk);
    #1 checks++;
    if (so_rgb !== 12'h008) begin errors++; $display("FAIL pass_thru: got %h expected %h", so_rgb, 12'h008); end
    @(negedge clk);
    si_rgb = 12'h0AB;
    checks++;
    if (so_rgb !== 12'h008) begin errors++; $display("FAIL latency_hold: got %h expected %h", so_rgb, 12'h008); end
    @(posedge clk);
    #1 checks++;
    if (so_rgb !== 12'h0AB) begin errors++; $display("FAIL latency_1: got %h expected %h", so_rgb, 12'h0AB); end
  endtask

  task automatic test_grid();
    wr(3'd3, 32'd15);
    wr(3'd1, 32'h0032_0064);
    wr(3'd5, 32'h0000_0FFF);
    wr(3'd0, 32'd1);
    frame();
    px(100, 50, 12'h123, got); checks++;
    if (got !== 12'hFFF) begin errors++; $display("FAIL grid_origin: got %h expected %h", got, 12'hFFF); end
    px(164, 60, 12'h123, got); checks++;
    if (got !== 12'hFFF) begin errors++; $display("FAIL grid_line: got %h expected %h", got, 12'hFFF); end
    px(120, 70, 12'h456, got); checks++;
    if (got !== 12'h456) begin errors++; $display("FAIL grid_interior: got %h expected %h", got, 12'h456); end
    px(292, 50, 12'h789, got); checks++;
    if (got !== 12'h789) begin errors++; $display("FAIL grid_right_out: got %h expected %h", got, 12'h789); end
    px(99, 50, 12'h321, got); checks++;
    if (got !== 12'h321) begin errors++; $display("FAIL grid_left_out: got %h expected %h", got, 12'h321); end
    px(291, 241, 12'h321, got); checks++;
    if (got !== 12'hFFF) begin errors++; $display("FAIL grid_far_corner: got %h expected %h", got, 12'hFFF); end
  endtask

  task automatic test_marks();
    wr(3'd4, 32'h00F0_00F0);
    wr(3'd2, 32'h0000_0009);
    px(120, 70, 12'h456, got); checks++;
    if (got !== 12'h456) begin errors++; $display("FAIL marks_pending: got %h expected %h", got, 12'h456); end
    frame();
    px(120, 70, 12'h456, got); checks++;
    if (got !== 12'h0F0) begin errors++; $display("FAIL marks_x: got %h expected %h", got, 12'h0F0); end
    px(195, 58, 12'h456, got); checks++;
    if (got !== 12'hF00) begin errors++; $display("FAIL marks_o_vertex: got %h expected %h", got, 12'hF00); end
    px(130, 60, 12'h456, got); checks++;
    if (got !== 12'h456) begin errors++; $display("FAIL marks_x_gap: got %h expected %h", got, 12'h456); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    x = 11'd0; y = 11'd0;
    @(negedge clk);
    x = 11'd1;
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = 14'd2; wr_data = 32'h0000_0010;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
    fcnt++;
    px(248, 70, 12'h456, got); checks++;
    if (got !== 12'h0F0) begin errors++; $display("FAIL bypass_new: got %h expected %h", got, 12'h0F0); end
    px(120, 70, 12'h456, got); checks++;
    if (got !== 12'h456) begin errors++; $display("FAIL bypass_old_gone: got %h expected %h", got, 12'h456); end
  endtask

  task automatic test_blink();
    wr(3'd5, 32'h00FF_0FFF);
    wr(3'd0, 32'd3);
    wr(3'd3, 32'd4);
    for (int f = 0; f < 40; f++) begin
      frame();
      px(225, 144, 12'h123, got);
      exp = ((fcnt % 32) < 16) ? 12'hFF0 : 12'h123;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL blink_frame%0d: got %h expected %h", fcnt % 32, got, exp); end
    end
    wr(3'd3, 32'd12);
    for (int f = 0; f < 32; f++) begin
      frame();
      px(225, 144, 12'h123, got);
      checks++;
      if (got !== 12'h123) begin errors++; $display("FAIL no_cursor_frame%0d: got %h expected %h", fcnt % 32, got, 12'h123); end
    end
  endtask

  task automatic test_win();
    wr(3'd0, 32'd1);
    wr(3'd3, 32'd4);
    wr(3'd2, 32'h0000_0300);
    frame();
    px(194, 144, 12'h123, got); checks++;
    if (got !== 12'hFF0) begin errors++; $display("FAIL win_fill: got %h expected %h", got, 12'hFF0); end
    px(225, 144, 12'h123, got); checks++;
    if (got !== 12'hFF0) begin errors++; $display("FAIL win_outline: got %h expected %h", got, 12'hFF0); end
    px(166, 144, 12'h123, got); checks++;
    if (got !== 12'hFF0) begin errors++; $display("FAIL cursor_over_grid: got %h expected %h", got, 12'hFF0); end
    wr(3'd2, 32'h0000_0100);
    frame();
    px(194, 144, 12'h123, got); checks++;
    if (got !== 12'h0F0) begin errors++; $display("FAIL x_under_cursor: got %h expected %h", got, 12'h0F0); end
    px(225, 144, 12'h123, got); checks++;
    if (got !== 12'hFF0) begin errors++; $display("FAIL cursor_edge_x_cell: got %h expected %h", got, 12'hFF0); end
    px(100, 144, 12'h123, got); checks++;
    if (got !== 12'hFFF) begin errors++; $display("FAIL grid_other_cell: got %h expected %h", got, 12'hFFF); end
  endtask

  task automatic test_disable();
    wr(3'd0, 32'd0);
    px(100, 50, 12'h5A5, got); checks++;
    if (got !== 12'h5A5) begin errors++; $display("FAIL disable_pass: got %h expected %h", got, 12'h5A5); end
    px(194, 144, 12'h0C3, got); checks++;
    if (got !== 12'h0C3) begin errors++; $display("FAIL disable_mark: got %h expected %h", got, 12'h0C3); end
  endtask

  initial begin
    test_reset();
    test_grid();
    test_marks();
    test_bypass();
    test_blink();
    test_win();
    test_disable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
